// File: rtl/mio_pkg.sv
// Shared types and constants for the mio_responder memory/IO bus target.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mio_state_e;

  localparam logic [3:0]  IO_BASE_NIBBLE = 4'hF;
  localparam logic [27:0] IO_OFS_OUT     = 28'h000_0000;
  localparam logic [27:0] IO_OFS_SW      = 28'h000_0004;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mio_responder_if.sv
// CPU-side request/response bundle between the multi-cycle CPU and mio_responder.
interface mio_responder_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] M_addr;
  logic [31:0] data_out;
  logic [31:0] data2CPU;
  logic        MIO_ready;

  modport master (
    output mem_req,
    output mem_we,
    output M_addr,
    output data_out,
    input  data2CPU,
    input  MIO_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  M_addr,
    input  data_out,
    output data2CPU,
    output MIO_ready
  );

endinterface

// File: rtl/mio_ram.sv
// Word RAM behind mio_responder: one synchronous write port, asynchronous read, no reset.
module mio_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] words [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      words[addr] <= wdata;
    end
  end

  assign rdata = words[addr];

endmodule

// File: rtl/mio_responder.sv
// Wait-state memory/IO bus responder for the multi-cycle CPU.
// Define MIO_IO_EN to add the IO window at M_addr[31:28]=4'hF (io_out, sw_in ports).
module mio_responder
  import mio_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  mio_responder_if.slave bus
`ifdef MIO_IO_EN
  ,
  input  logic [31:0]    sw_in,
  output logic [31:0]    io_out
`endif
);

  mio_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;

  logic [ADDR_W-1:0] cur_idx;
  logic              cur_we;
  logic [31:0]       ram_rdata;
  logic [31:0]       rd_word;
  logic              ram_we;

`ifdef MIO_IO_EN
  logic              io_sel_q, io_sel_d;
  logic [25:0]       ofs_q, ofs_d;
  logic [31:0]       io_out_q, io_out_d;
  logic [31:0]       sw_meta_q, sw_meta_d;
  logic [31:0]       sw_sync_q, sw_sync_d;
  logic              cur_io;
  logic [25:0]       cur_ofs;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.M_addr[1:0], bus.M_addr[31:ADDR_W+2]};

  // A zero-wait read completes on the accept edge, so IDLE decodes the live bus.
  always_comb begin
    if (state_q == IDLE) begin
      cur_idx = bus.M_addr[ADDR_W+1:2];
      cur_we  = bus.mem_we;
    end else begin
      cur_idx = idx_q;
      cur_we  = we_q;
    end
`ifdef MIO_IO_EN
    if (state_q == IDLE) begin
      cur_io  = (bus.M_addr[31:28] == IO_BASE_NIBBLE);
      cur_ofs = bus.M_addr[27:2];
    end else begin
      cur_io  = io_sel_q;
      cur_ofs = ofs_q;
    end
`endif
  end

  always_comb begin
    rd_word = ram_rdata;
`ifdef MIO_IO_EN
    if (cur_io) begin
      if (cur_ofs == IO_OFS_OUT[27:2]) begin
        rd_word = io_out_q;
      end else if (cur_ofs == IO_OFS_SW[27:2]) begin
        rd_word = sw_sync_q;
      end else begin
        rd_word = '0;
      end
    end
`endif
  end

  mio_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cur_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    ram_we  = 1'b0;
`ifdef MIO_IO_EN
    io_sel_d  = io_sel_q;
    ofs_d     = ofs_q;
    io_out_d  = io_out_q;
    sw_meta_d = sw_in;
    sw_sync_d = sw_meta_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          idx_d   = cur_idx;
          we_d    = bus.mem_we;
          wdata_d = bus.data_out;
          cnt_d   = CNT_W'(WAIT_CYCLES);
`ifdef MIO_IO_EN
          io_sel_d = cur_io;
          ofs_d    = cur_ofs;
`endif
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            ready_d = 1'b1;
            if (!cur_we) begin
              rdata_d = rd_word;
            end
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A dropped request abandons the transfer before anything is committed.
        if (!bus.mem_req) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          ready_d = 1'b1;
          if (!cur_we) begin
            rdata_d = rd_word;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
`ifdef MIO_IO_EN
        if (we_q && io_sel_q) begin
          if (ofs_q == IO_OFS_OUT[27:2]) begin
            io_out_d = wdata_q;
          end
        end else begin
          ram_we = we_q;
        end
`else
        ram_we = we_q;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
`ifdef MIO_IO_EN
      io_sel_q  <= 1'b0;
      ofs_q     <= '0;
      io_out_q  <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
`ifdef MIO_IO_EN
      io_sel_q  <= io_sel_d;
      ofs_q     <= ofs_d;
      io_out_q  <= io_out_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
`endif
    end
  end

  assign bus.data2CPU  = rdata_q;
  assign bus.MIO_ready = ready_q;
`ifdef MIO_IO_EN
  assign io_out = io_out_q;
`endif

endmodule
